fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction fetch unit with a prefetch buffer, replacing the single-cycle, zero-latency fetch path of the current processor. It owns the program counter, issues word fetches to an instruction memory with variable response latency, buffers up to DEPTH fetched instructions with their PC+4, and delivers them to decode over a valid/ready handshake. Start-address load and branch/jump redirects flush the buffer and cancel any in-flight fetch.

## Interface
- ADDR_W, 32, PC and memory address width (≥ 3)
- DATA_W, 32, instruction width
- DEPTH, 4, buffer entries; power of two, ≥ 2
- RESET_ADDR, 0, PC value after reset (low two bits must be 0)

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- pcSelect  in  1  load startAddress into PC and flush (start/restart)
- startAddress  in  ADDR_W  start PC
- redirect  in  1  taken branch/jump from execute; flush and load redirectAddr
- redirectAddr  in  ADDR_W  redirect target
- imemReq  out  1  fetch request, registered
- imemAddr  out  ADDR_W  fetch address, registered, stable while imemReq high
- imemValid  in  1  one-cycle response strobe for the outstanding request
- imemData  in  DATA_W  response word, valid with imemValid
- instrValid  out  1  buffer head is valid
- instruction  out  DATA_W  buffer head instruction
- pcPlus4  out  ADDR_W  PC of head instruction + 4 (link and branch base)
- instrReady  in  1  decode accepts head this cycle

## Operation
- State: pc, FIFO (DEPTH × {instruction, pcPlus4}), count (0..DEPTH), busy (one request outstanding), drop (outstanding response to be discarded), imemReq, imemAddr.
- At most one outstanding request. imemReq high ⇔ busy. Memory returns exactly one imemValid per request; imemValid while !busy is ignored.
- Pop: instrValid && instrReady && no flush this cycle → head removed.
- Response: busy && imemValid → busy clears; if !drop and no flush this cycle, push {imemData, imemAddr+4}; drop clears.
- Issue: when (!busy || imemValid) and no flush, and count_next < DEPTH, where count_next is count after this cycle's push/pop → imemReq←1, imemAddr←pc, pc←pc+4. Back-to-back issue is allowed in the response cycle.
- Flush (pcSelect or redirect): count←0; pc←target with low two bits forced to 0. pcSelect takes priority over redirect. If busy and no imemValid this cycle, drop←1 and imemReq/imemAddr stay unchanged until the response arrives. If imemValid arrives this cycle, the response is discarded and imemReq←0. No issue occurs in a flush cycle.
- Priority: reset > pcSelect > redirect > response/pop/issue.
- Arithmetic: pc+4 and imemAddr+4 are modulo 2^ADDR_W; wrap from all-ones−3 to 0 is legal.
- FIFO read/write pointers are log2(DEPTH) bits and wrap naturally. Simultaneous push and pop when full or empty is legal, and count stays consistent. The issue rule guarantees a push never lands when the buffer is full.

## Timing
- Reset (async assert, sync release): pc=RESET_ADDR, count=0, busy=0, drop=0, imemReq=0, imemAddr=0, instrValid=0; instruction and pcPlus4 show the undefined head and are don't-care while instrValid=0.
- First imemReq: rising edge after the first clock with reset low (1 cycle).
- Latency from imemValid to instrValid: 1 cycle (pushed at the edge, visible after it).
- Redirect to first new request: flush at edge N. If not busy, imemReq for the target rises at edge N+1. If busy, it rises at the edge where the dropped response is consumed.
- instrValid = (count≠0), combinational from registered state. instruction and pcPlus4 are read combinationally from the head entry. There is no combinational path from instrReady or imemValid to any output.
- Reset asserted mid-request: all state clears immediately. The memory must tolerate an abandoned request.

## Test plan
- Reset with RESET_ADDR=0x100, memory latency 0 (imemValid the cycle after imemReq rises), instrReady=1 → imemAddr sequence 0x100, 0x104, 0x108…; pcPlus4 0x104, 0x108…; instruction equals memory contents in order.
- instrReady=0, DEPTH=4, latency 2 → exactly 4 fetches issue, then imemReq stays 0; count=4. Raising instrReady drains 0x100..0x10C in order, and fetching resumes at 0x110.
- Latency 3, redirect to 0x2000 one cycle after a request to 0x108 is issued → that response is discarded, instrValid=0, next imemAddr=0x2000, first delivered pcPlus4=0x2004.
- redirect and imemValid in the same cycle, and pcSelect=1 (startAddress=0x40) together with redirect=1 (0x80) → response dropped; next fetch is 0x40.
- ADDR_W=8, start 0xF8 → addresses 0xF8, 0xFC, 0x00; pcPlus4 0xFC, 0x00, 0x04. redirectAddr=0x33 → fetch at 0x30.
- Reset pulsed while busy with count=2 → instrValid and imemReq fall asynchronously. After release, fetch restarts at RESET_ADDR, and a late imemValid with no request outstanding is ignored.

Source files
------------

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
// Instruction fetch unit: owns the PC, keeps one word fetch in flight and
// buffers up to DEPTH {instruction, pc+4} entries for decode.
// Latency: request 1 cycle after reset release or a flush; imemValid -> instrValid 1 cycle.
// Backpressure: instrReady low fills the buffer; new fetches stop when it would overflow.
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   pcSelect/startAddress      load a start PC and flush (wins over redirect)
//   redirect/redirectAddr      taken branch/jump: flush and load target
//   imemReq/imemAddr           registered fetch request, one outstanding at a time
//   imemValid/imemData         single-cycle response strobe for the outstanding request
//   instrValid/instruction/pcPlus4/instrReady   head entry to decode, valid/ready
module fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pcSelect,
  input  logic [ADDR_W-1:0] startAddress,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirectAddr,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemValid,
  input  logic [DATA_W-1:0] imemData,
  output logic              instrValid,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] pcPlus4,
  input  logic              instrReady
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_addr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              busy;
  logic              drop;

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] link_mem  [DEPTH];

  logic              flush;
  logic [ADDR_W-1:0] flush_target;
  logic              pop;
  logic              resp;
  logic              push;
  logic              issue;

  always_comb begin
    flush        = pcSelect | redirect;
    // Targets are word-aligned by clearing the two low bits.
    flush_target = (pcSelect ? startAddress : redirectAddr) & ~ADDR_W'(3);
    pop          = (count != '0) && instrReady && !flush;
    resp         = busy && imemValid;
    push         = resp && !drop && !flush;
    count_next   = count + CNT_W'(push) - CNT_W'(pop);
    // A new request may go out in the same cycle the previous one returns;
    // gating on count_next keeps a future push from ever hitting a full buffer.
    issue        = (!busy || imemValid) && !flush && (count_next < FULL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_ADDR;
      req_addr <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      busy     <= 1'b0;
      drop     <= 1'b0;
    end else if (flush) begin
      pc     <= flush_target;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      if (busy) begin
        if (imemValid) begin
          // Response arrives with the flush: discard it and go idle.
          busy <= 1'b0;
          drop <= 1'b0;
        end else begin
          // Keep the request on the bus until memory answers, then discard.
          drop <= 1'b1;
        end
      end
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (issue) begin
        busy     <= 1'b1;
        drop     <= 1'b0;
        req_addr <= pc;
        pc       <= pc + ADDR_W'(4);
      end else if (resp) begin
        busy <= 1'b0;
        drop <= 1'b0;
      end
    end
  end

  // Buffer storage needs no reset; count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imemData;
      link_mem[wr_ptr]  <= req_addr + ADDR_W'(4);
    end
  end

  assign imemReq     = busy;
  assign imemAddr    = req_addr;
  assign instrValid  = (count != '0);
  assign instruction = instr_mem[rd_ptr];
  assign pcPlus4     = link_mem[rd_ptr];

endmodule

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcSelect, redirect, imemValid, instrReady;
  logic [31:0] startAddress, redirectAddr, imemData;
  logic        imemReq, instrValid;
  logic [31:0] imemAddr, instruction, pcPlus4;

  logic        b_pcSelect, b_redirect, b_imemValid, b_instrReady;
  logic [7:0]  b_startAddress, b_redirectAddr;
  logic [31:0] b_imemData;
  logic        b_imemReq, b_instrValid;
  logic [7:0]  b_imemAddr, b_pcPlus4;
  logic [31:0] b_instruction;

  int total = 0;
  int bad = 0;

  bit mem_en = 0;
  int mem_lat = 0;
  int wait_cnt = 0;
  bit b_mem_en = 0;

  always #5 clk = ~clk;

  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_ADDR(32'h100)) dut_a (
    .clk(clk), .reset(reset),
    .pcSelect(pcSelect), .startAddress(startAddress),
    .redirect(redirect), .redirectAddr(redirectAddr),
    .imemReq(imemReq), .imemAddr(imemAddr),
    .imemValid(imemValid), .imemData(imemData),
    .instrValid(instrValid), .instruction(instruction),
    .pcPlus4(pcPlus4), .instrReady(instrReady)
  );

  fetch_queue #(.ADDR_W(8), .DATA_W(32), .DEPTH(4), .RESET_ADDR(8'h00)) dut_b (
    .clk(clk), .reset(reset),
    .pcSelect(b_pcSelect), .startAddress(b_startAddress),
    .redirect(b_redirect), .redirectAddr(b_redirectAddr),
    .imemReq(b_imemReq), .imemAddr(b_imemAddr),
    .imemValid(b_imemValid), .imemData(b_imemData),
    .instrValid(b_instrValid), .instruction(b_instruction),
    .pcPlus4(b_pcPlus4), .instrReady(b_instrReady)
  );

  function automatic logic [31:0] memw(logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  function automatic logic [31:0] memw_b(logic [7:0] a);
    return {24'hBEEF_00, a};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model for the wide instance: answers after mem_lat idle cycles.
  initial forever begin
    @(posedge clk);
    #1;
    if (!mem_en) wait_cnt = 0;
    else if (reset) begin
      imemValid = 1'b0;
      wait_cnt = 0;
    end else if (imemValid) imemValid = 1'b0;
    else if (imemReq) begin
      if (wait_cnt >= mem_lat) begin
        imemValid = 1'b1;
        imemData = memw(imemAddr);
        wait_cnt = 0;
      end else wait_cnt++;
    end
  end

  // Zero-latency memory model for the 8-bit instance.
  initial forever begin
    @(posedge clk);
    #1;
    if (b_mem_en) begin
      if (reset) b_imemValid = 1'b0;
      else if (b_imemValid) b_imemValid = 1'b0;
      else if (b_imemReq) begin
        b_imemValid = 1'b1;
        b_imemData = memw_b(b_imemAddr);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    pcSelect = 0; redirect = 0; instrReady = 0;
    b_pcSelect = 0; b_redirect = 0; b_instrReady = 0;
    if (!mem_en) imemValid = 0;
    if (!b_mem_en) b_imemValid = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_pop(output logic [31:0] pc4, output logic [31:0] ins, output bit ok);
    ok = 0; pc4 = '0; ins = '0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (instrValid && instrReady) begin
        ok = 1; pc4 = pcPlus4; ins = instruction;
      end
      tick();
    end
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] raddr;
    logic        iv;
    logic [31:0] idata;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t tv[14];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p4, ins, old, newa;
    logic [7:0]  b_old, b_new;
    logic [7:0]  ra[$];
    logic [7:0]  pp[$];
    logic [31:0] pi[$];
    logic [7:0]  ea[3];
    logic [7:0]  ep[3];
    bit ok, found, got, early, had;
    int resp_n;

    // redir raddr iv idata rdy | req addr vld instr pc4 (latency-0 run, then redirect-drop)
    tv[0]  = '{1'b0, 32'h0,    1'b0, 32'h0,         1'b1, 1'b0, 32'h0,    1'b0, 32'h0,         32'h0};
    tv[1]  = '{1'b0, 32'h0,    1'b1, 32'hC0DE_0100, 1'b1, 1'b1, 32'h100,  1'b0, 32'h0,         32'h0};
    tv[2]  = '{1'b0, 32'h0,    1'b1, 32'hC0DE_0104, 1'b1, 1'b1, 32'h104,  1'b1, 32'hC0DE_0100, 32'h104};
    tv[3]  = '{1'b0, 32'h0,    1'b1, 32'hC0DE_0108, 1'b1, 1'b1, 32'h108,  1'b1, 32'hC0DE_0104, 32'h108};
    tv[4]  = '{1'b0, 32'h0,    1'b0, 32'h0,         1'b0, 1'b1, 32'h10C,  1'b1, 32'hC0DE_0108, 32'h10C};
    tv[5]  = '{1'b0, 32'h0,    1'b1, 32'hC0DE_010C, 1'b0, 1'b1, 32'h10C,  1'b1, 32'hC0DE_0108, 32'h10C};
    tv[6]  = '{1'b0, 32'h0,    1'b0, 32'h0,         1'b1, 1'b1, 32'h110,  1'b1, 32'hC0DE_0108, 32'h10C};
    tv[7]  = '{1'b0, 32'h0,    1'b0, 32'h0,         1'b1, 1'b1, 32'h110,  1'b1, 32'hC0DE_010C, 32'h110};
    tv[8]  = '{1'b0, 32'h0,    1'b1, 32'hC0DE_0110, 1'b1, 1'b1, 32'h110,  1'b0, 32'h0,         32'h0};
    tv[9]  = '{1'b0, 32'h0,    1'b0, 32'h0,         1'b1, 1'b1, 32'h114,  1'b1, 32'hC0DE_0110, 32'h114};
    tv[10] = '{1'b1, 32'h2002, 1'b0, 32'h0,         1'b1, 1'b1, 32'h114,  1'b0, 32'h0,         32'h0};
    tv[11] = '{1'b0, 32'h0,    1'b1, 32'hC0DE_0114, 1'b1, 1'b1, 32'h114,  1'b0, 32'h0,         32'h0};
    tv[12] = '{1'b0, 32'h0,    1'b1, 32'hC0DE_2000, 1'b1, 1'b1, 32'h2000, 1'b0, 32'h0,         32'h0};
    tv[13] = '{1'b0, 32'h0,    1'b0, 32'h0,         1'b1, 1'b1, 32'h2004, 1'b1, 32'hC0DE_2000, 32'h2004};

    reset = 1'b1;
    pcSelect = 0; redirect = 0; imemValid = 0; instrReady = 0;
    startAddress = '0; redirectAddr = '0; imemData = '0;
    b_pcSelect = 0; b_redirect = 0; b_imemValid = 0; b_instrReady = 0;
    b_startAddress = '0; b_redirectAddr = '0; b_imemData = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_req", imemReq, 0);
    chk("rst_addr", imemAddr, 0);
    chk("rst_valid", instrValid, 0);
    chk("rst_b_req", b_imemReq, 0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      redirect = tv[i].redir; redirectAddr = tv[i].raddr;
      imemValid = tv[i].iv; imemData = tv[i].idata; instrReady = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), imemReq, tv[i].e_req);
      chk($sformatf("vec%0d_addr", i), imemAddr, tv[i].e_addr);
      chk($sformatf("vec%0d_valid", i), instrValid, tv[i].e_vld);
      if (tv[i].e_vld) begin
        chk($sformatf("vec%0d_instr", i), instruction, tv[i].e_instr);
        chk($sformatf("vec%0d_pc4", i), pcPlus4, tv[i].e_pc4);
      end
      tick();
    end
    redirect = 0; imemValid = 0;

    // Backpressure: exactly DEPTH fetches, then drain in order and resume.
    do_reset();
    mem_lat = 2; mem_en = 1; instrReady = 0; resp_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (imemReq && imemValid) resp_n++;
      tick();
    end
    @(negedge clk);
    chk("full_fetches", resp_n, 4);
    chk("full_req_low", imemReq, 0);
    chk("full_valid", instrValid, 1);
    chk("full_head_pc4", pcPlus4, 32'h104);
    tick();
    instrReady = 1;
    for (int k = 0; k < 5; k++) begin
      wait_pop(p4, ins, ok);
      chk($sformatf("drain%0d_seen", k), ok, 1);
      chk($sformatf("drain%0d_pc4", k), p4, 32'h104 + 32'(4 * k));
      chk($sformatf("drain%0d_instr", k), ins, memw(32'h100 + 32'(4 * k)));
    end

    // Redirect while a latency-3 fetch is outstanding.
    do_reset();
    mem_lat = 3; instrReady = 1; found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (imemReq && imemAddr == 32'h108) found = 1;
      tick();
    end
    chk("redir_found_108", found, 1);
    redirect = 1; redirectAddr = 32'h2000;
    tick();
    redirect = 0;
    @(negedge clk);
    chk("redir_flush_valid", instrValid, 0);
    chk("redir_req_held", imemReq, 1);
    chk("redir_addr_held", imemAddr, 32'h108);
    tick();
    got = 0; early = 0; newa = '0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (imemReq && imemAddr != 32'h108) begin
        got = 1; newa = imemAddr;
      end else if (instrValid) early = 1;
      tick();
    end
    chk("redir_new_addr", newa, 32'h2000);
    chk("redir_no_stale", early, 0);
    wait_pop(p4, ins, ok);
    chk("redir_pop_pc4", p4, 32'h2004);
    chk("redir_pop_instr", ins, memw(32'h2000));

    // Redirect coinciding with the response strobe.
    do_reset();
    mem_lat = 2; instrReady = 1; found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (imemReq && imemValid) found = 1;
      else tick();
    end
    chk("coinc_found", found, 1);
    redirect = 1; redirectAddr = 32'h3000;
    tick();
    redirect = 0;
    @(negedge clk);
    chk("coinc_req_low", imemReq, 0);
    chk("coinc_valid", instrValid, 0);
    tick();
    @(negedge clk);
    chk("coinc_req", imemReq, 1);
    chk("coinc_addr", imemAddr, 32'h3000);
    tick();
    wait_pop(p4, ins, ok);
    chk("coinc_pop_pc4", p4, 32'h3004);

    // pcSelect and redirect together: start address wins.
    found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (imemReq && !imemValid) found = 1;
      else tick();
    end
    chk("prio_found", found, 1);
    old = imemAddr;
    pcSelect = 1; startAddress = 32'h40; redirect = 1; redirectAddr = 32'h80;
    tick();
    pcSelect = 0; redirect = 0;
    got = 0; newa = '0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (imemReq && imemAddr != old) begin
        got = 1; newa = imemAddr;
      end
      tick();
    end
    chk("prio_addr", newa, 32'h40);
    wait_pop(p4, ins, ok);
    chk("prio_pop_pc4", p4, 32'h44);

    // 8-bit address wrap and redirect alignment on the narrow instance.
    mem_en = 0;
    do_reset();
    b_mem_en = 1; b_instrReady = 1; b_pcSelect = 1; b_startAddress = 8'hF8;
    tick();
    b_pcSelect = 0;
    repeat (16) begin
      @(negedge clk);
      if (b_imemReq && b_imemValid) ra.push_back(b_imemAddr);
      if (b_instrValid && b_instrReady) begin
        pp.push_back(b_pcPlus4);
        pi.push_back(b_instruction);
      end
      tick();
    end
    ea = '{8'hF8, 8'hFC, 8'h00};
    ep = '{8'hFC, 8'h00, 8'h04};
    chk("wrap_nreq", 32'(ra.size() >= 3), 1);
    chk("wrap_npop", 32'(pp.size() >= 3), 1);
    for (int k = 0; k < 3; k++) begin
      if (k < ra.size()) chk($sformatf("wrap_addr%0d", k), ra[k], ea[k]);
      if (k < pp.size()) begin
        chk($sformatf("wrap_pc4_%0d", k), pp[k], ep[k]);
        chk($sformatf("wrap_instr%0d", k), pi[k], memw_b(ea[k]));
      end
    end
    had = b_imemReq; b_old = b_imemAddr;
    b_redirect = 1; b_redirectAddr = 8'h33;
    tick();
    b_redirect = 0;
    got = 0; b_new = '0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (b_imemReq && (!had || b_imemAddr != b_old)) begin
        got = 1; b_new = b_imemAddr;
      end
      tick();
    end
    chk("b_redir_addr", b_new, 8'h30);
    got = 0; b_new = '0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (b_instrValid && b_instrReady) begin
        got = 1; b_new = b_pcPlus4;
      end
      tick();
    end
    chk("b_redir_pc4", b_new, 8'h34);
    b_mem_en = 0; b_imemValid = 0;

    // Asynchronous reset while busy with two entries buffered.
    do_reset();
    mem_lat = 2; mem_en = 1; instrReady = 0; resp_n = 0; found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (imemReq && imemValid) resp_n++;
      if (resp_n == 2 && imemReq && !imemValid) found = 1;
      else tick();
    end
    chk("arst_setup", found, 1);
    chk("arst_pre_valid", instrValid, 1);
    #1 reset = 1'b1;
    #1;
    chk("arst_valid", instrValid, 0);
    chk("arst_req", imemReq, 0);
    chk("arst_addr", imemAddr, 0);
    mem_en = 0; imemValid = 0;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("arst_idle_req", imemReq, 0);
    imemValid = 1; imemData = 32'hDEAD_BEEF;
    tick();
    imemValid = 0; mem_en = 1; instrReady = 1;
    @(negedge clk);
    chk("arst_restart_req", imemReq, 1);
    chk("arst_restart_addr", imemAddr, 32'h100);
    chk("arst_stray_ignored", instrValid, 0);
    tick();
    wait_pop(p4, ins, ok);
    chk("arst_pop_pc4", p4, 32'h104);
    chk("arst_pop_instr", ins, memw(32'h100));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
